sta_pattern_tx: RTL and testbench

STA_PATTERN_TX -- requirements
Module: sta_pattern_tx

---
 rtl/sta_pkg.sv | 25 ++
 rtl/sta_path_buf.sv | 31 +++
 rtl/sta_pattern_tx.sv | 196 +++++++++++++++++++
 tb/tb_sta_pattern_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sta_pkg.sv
// ============================================================================
// Module   : sta_pkg
// Brief    : Shared sizes and FSM state encoding for the STA pattern driver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sta_pkg;
   localparam int NODE_NUM    = 16;
   localparam int EDGE_NUM    = 32;
   localparam int DELAY_W     = 4;
   localparam int NODE_W      = 4;
   localparam int WDLY_W      = 8;
   localparam int TIMEOUT_CYC = 1024;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEND = 3'd1,
      ST_WAIT = 3'd2,
      ST_RECV = 3'd3,
      ST_DONE = 3'd4
   } sta_state_e;
endpackage

`default_nettype wire

// File: rtl/sta_path_buf.sv
// ============================================================================
// Module   : sta_path_buf
// Brief    : 16x4 path register file, one write port, combinational read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sta_path_buf
   import sta_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [3:0]        waddr_i,
   input  logic [NODE_W-1:0] wdata_i,
   input  logic [3:0]        raddr_i,
   output logic [NODE_W-1:0] rdata_o
);

   logic [NODE_W-1:0] mem_q [NODE_NUM];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/sta_pattern_tx.sv
// ============================================================================
// Module   : sta_pattern_tx
// Brief    : Streams a 32-beat node/edge pattern into an STA core and captures
//            the worst delay and critical path it returns.
//            Optional macro STA_TX_TIMEOUT_EN adds a WAIT-state timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sta_pattern_tx
   import sta_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic               cfg_sel,
   input  logic [4:0]         cfg_addr,
   input  logic [7:0]         cfg_data,
   input  logic               start,
   output logic               busy,
   output logic               in_valid,
   output logic [DELAY_W-1:0] delay,
   output logic [NODE_W-1:0]  source,
   output logic [NODE_W-1:0]  destination,
   input  logic               out_valid,
   input  logic [WDLY_W-1:0]  worst_delay,
   input  logic [NODE_W-1:0]  path,
   output logic               done,
   output logic               err,
   output logic [WDLY_W-1:0]  res_delay,
   output logic [4:0]         res_len,
   input  logic [3:0]         rd_addr,
   output logic [NODE_W-1:0]  rd_data
);

   sta_state_e          state_q, state_d;
   logic [4:0]          beat_q, beat_d;
   logic                in_valid_q, in_valid_d;
   logic [DELAY_W-1:0]  delay_q, delay_d;
   logic [NODE_W-1:0]   src_q, src_d;
   logic [NODE_W-1:0]   dst_q, dst_d;
   logic                err_q, err_d;
   logic [WDLY_W-1:0]   res_delay_q, res_delay_d;
   logic [4:0]          res_len_q, res_len_d;
   logic                buf_we;
   logic [3:0]          buf_waddr;
   logic                tmo_hit;

   logic [DELAY_W-1:0]  node_ram_q [NODE_NUM];
   logic [7:0]          edge_ram_q [EDGE_NUM];

   // Config RAMs are not reset so a pattern survives rst.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && cfg_we) begin
         if (cfg_sel) begin
            edge_ram_q[cfg_addr] <= cfg_data;
         end else begin
            node_ram_q[cfg_addr[3:0]] <= cfg_data[DELAY_W-1:0];
         end
      end
   end

`ifdef STA_TX_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC);
   logic [TMO_W-1:0] tmo_q;

   always_ff @(posedge clk) begin
      if (rst || state_q != ST_WAIT) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   assign tmo_hit = (state_q == ST_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         in_valid_q  <= 1'b0;
         delay_q     <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         err_q       <= 1'b0;
         res_delay_q <= '0;
         res_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         in_valid_q  <= in_valid_d;
         delay_q     <= delay_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         err_q       <= err_d;
         res_delay_q <= res_delay_d;
         res_len_q   <= res_len_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      in_valid_d  = 1'b0;
      delay_d     = '0;
      src_d       = '0;
      dst_d       = '0;
      err_d       = err_q;
      res_delay_d = res_delay_q;
      res_len_d   = res_len_q;
      buf_we      = 1'b0;
      buf_waddr   = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               res_len_d   = '0;
               err_d       = 1'b0;
               res_delay_d = '0;
               beat_d      = '0;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            in_valid_d     = 1'b1;
            delay_d        = beat_q[4] ? '0 : node_ram_q[beat_q[3:0]];
            {src_d, dst_d} = edge_ram_q[beat_q];
            beat_d         = beat_q + 5'd1;
            // A result arriving this early is a core protocol violation.
            if (out_valid) begin
               err_d = 1'b1;
            end
            if (beat_q == 5'(EDGE_NUM - 1)) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (out_valid) begin
               res_delay_d = worst_delay;
               buf_we      = 1'b1;
               buf_waddr   = '0;
               res_len_d   = 5'd1;
               state_d     = ST_RECV;
            end else if (tmo_hit) begin
               err_d     = 1'b1;
               res_len_d = '0;
               state_d   = ST_DONE;
            end
         end
         ST_RECV: begin
            if (out_valid) begin
               if (res_len_q < 5'(NODE_NUM)) begin
                  buf_we    = 1'b1;
                  buf_waddr = res_len_q[3:0];
                  res_len_d = res_len_q + 5'd1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   sta_path_buf u_path_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (buf_waddr),
      .wdata_i (path),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign in_valid    = in_valid_q;
   assign delay       = delay_q;
   assign source      = src_q;
   assign destination = dst_q;
   assign err         = err_q;
   assign res_delay   = res_delay_q;
   assign res_len     = res_len_q;

endmodule

`default_nettype wire

// File: tb/tb_sta_pattern_tx.sv
// ============================================================================
// Module   : tb_sta_pattern_tx
// Brief    : Randomized self-checking bench for sta_pattern_tx against a
//            behavioural pattern/result model. Honours STA_TX_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sta_pattern_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic       cfg_sel = 1'b0;
   logic [4:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       start = 1'b0;
   logic       busy;
   logic       in_valid;
   logic [3:0] delay;
   logic [3:0] source;
   logic [3:0] destination;
   logic       out_valid = 1'b0;
   logic [7:0] worst_delay = '0;
   logic [3:0] path = '0;
   logic       done;
   logic       err;
   logic [7:0] res_delay;
   logic [4:0] res_len;
   logic [3:0] rd_addr = '0;
   logic [3:0] rd_data;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] m_node [16];
   logic [7:0] m_edge [32];
   logic [3:0] m_buf  [16];
   logic [3:0] resp_path [18];
   logic [7:0] resp_wd;

   sta_pattern_tx dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .start       (start),
      .busy        (busy),
      .in_valid    (in_valid),
      .delay       (delay),
      .source      (source),
      .destination (destination),
      .out_valid   (out_valid),
      .worst_delay (worst_delay),
      .path        (path),
      .done        (done),
      .err         (err),
      .res_delay   (res_delay),
      .res_len     (res_len),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic sel, input logic [4:0] addr, input logic [7:0] data);
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
      tick();
      cfg_we = 1'b0;
      if (sel) m_edge[addr] = data;
      else     m_node[addr[3:0]] = data[3:0];
   endtask

   // Launch a pattern and check all 32 beats; optionally disturb the DUT
   // with ignored start/cfg writes and early out_valid during SEND.
   task automatic send_and_check(input bit inject, output bit viol);
      logic [3:0] exp_dly;
      viol = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("first_beat_latency", in_valid, 0);
      for (int k = 0; k < 32; k++) begin
         tick();
         exp_dly = (k < 16) ? m_node[k] : 4'd0;
         chk($sformatf("beat%0d_valid", k), in_valid, 1);
         chk($sformatf("beat%0d_delay", k), delay, exp_dly);
         chk($sformatf("beat%0d_src", k), source, m_edge[k][7:4]);
         chk($sformatf("beat%0d_dst", k), destination, m_edge[k][3:0]);
         if (inject && k < 29) begin
            out_valid = 1'($urandom_range(0, 3) == 0);
            start     = 1'($urandom);
            cfg_we    = 1'($urandom);
            cfg_sel   = 1'($urandom);
            cfg_addr  = 5'($urandom);
            cfg_data  = 8'($urandom);
            if (out_valid) viol = 1'b1;
         end else begin
            out_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
         end
      end
      out_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
   endtask

   task automatic respond(input int len, input int gap, input bit viol, input bit b2b);
      int exp_len;
      exp_len = (len > 16) ? 16 : len;
      for (int g = 0; g < gap; g++) begin
         out_valid = 1'b0;
         tick();
         chk("wait_no_done", done, 0);
      end
      for (int i = 0; i < len; i++) begin
         out_valid   = 1'b1;
         path        = resp_path[i];
         worst_delay = (i == 0) ? resp_wd : 8'($urandom);
         if (i < 16) m_buf[i] = resp_path[i];
         tick();
         chk("no_early_done", done, 0);
      end
      out_valid = 1'b0; worst_delay = '0; path = '0;
      tick();
      chk("done_pulse", done, 1);
      chk("res_delay", res_delay, resp_wd);
      chk("res_len", res_len, exp_len);
      chk("err", err, (viol || len > 16) ? 1 : 0);
      if (b2b) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      tick();
      chk("b2b_start_ignored", busy, 0);
      chk("res_len_held", res_len, exp_len);
      chk("res_delay_held", res_delay, resp_wd);
      for (int a = 0; a < exp_len; a++) begin
         rd_addr = 4'(a);
         #1;
         chk($sformatf("rd_path%0d", a), rd_data, m_buf[a]);
      end
   endtask

   initial begin
      bit viol;
      int len;
      int cyc;
      bit seen;

      tick(); tick();
      chk("rst_in_valid", in_valid, 0);
      chk("rst_delay", delay, 0);
      chk("rst_source", source, 0);
      chk("rst_destination", destination, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_res_delay", res_delay, 0);
      chk("rst_res_len", res_len, 0);
      rst = 1'b0;
      tick();

      // Directed pattern and 4-node response.
      for (int i = 0; i < 16; i++) cfg_write(1'b0, 5'(i), 8'(i));
      for (int k = 0; k < 32; k++) cfg_write(1'b1, 5'(k), {4'(k), 4'(k + 1)});
      send_and_check(1'b0, viol);
      resp_wd = 8'd37;
      resp_path[0] = 4'd0; resp_path[1] = 4'd3; resp_path[2] = 4'd7; resp_path[3] = 4'd1;
      respond(4, 2, viol, 1'b1);
      rd_addr = 4'd2;
      #1;
      chk("rd_addr2", rd_data, 4'd7);

      // Overlong response.
      send_and_check(1'b0, viol);
      resp_wd = 8'($urandom);
      for (int i = 0; i < 18; i++) resp_path[i] = 4'($urandom);
      respond(18, 1, viol, 1'b0);

      // Randomized patterns with ignored disturbances during SEND.
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 16; i++) if ($urandom_range(0, 1) == 1) cfg_write(1'b0, 5'(i), 8'($urandom));
         for (int k = 0; k < 32; k++) if ($urandom_range(0, 1) == 1) cfg_write(1'b1, 5'(k), 8'($urandom));
         send_and_check(1'b1, viol);
         len = $urandom_range(1, 18);
         resp_wd = 8'($urandom);
         for (int i = 0; i < 18; i++) resp_path[i] = 4'($urandom);
         respond(len, $urandom_range(1, 4), viol, 1'($urandom));
      end

      // Reset in the middle of SEND, then replay from retained RAMs.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k <= 10; k++) tick();
      chk("pre_rst_beat10_delay", delay, m_node[10]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_abort_in_valid", in_valid, 0);
      chk("rst_abort_busy", busy, 0);
      chk("rst_abort_done", done, 0);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("rst_abort_no_done", seen, 0);
      send_and_check(1'b0, viol);
      resp_wd = 8'($urandom);
      for (int i = 0; i < 18; i++) resp_path[i] = 4'($urandom);
      respond(5, 1, viol, 1'b0);

      // No core response at all.
      send_and_check(1'b0, viol);
`ifdef STA_TX_TIMEOUT_EN
      cyc = 0;
      while (!done && cyc < 1200) begin
         tick();
         cyc++;
      end
      chk("timeout_cycles", cyc, 1024);
      chk("timeout_err", err, 1);
      chk("timeout_res_len", res_len, 0);
      tick();
`else
      seen = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("no_timeout_done", seen, 0);
      chk("no_timeout_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("recover_busy", busy, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
